led_shift_sequencer: RTL and testbench
======================================

// Module: led_shift_sequencer
// PURPOSE
//   Controller that sequences the 8-bit LED shift-register datapath under ClockBaseTop.
//   Divides CLK into a shift tick and loads a seed pattern into the register.
//   Issues one shift strobe per tick with direction and serial-in bit chosen by mode:
//   rotate, fill-zero with auto-reload, bounce, or hold.
//   Reads the register contents back (sr_q) to make end-of-pattern decisions.
// PARAMETERS
//   WIDTH     8          shift-register width
//   TICK_DIV  12500000   CLK cycles per shift tick (8 Hz at 100 MHz); must be >= 2
//   CNT_W     24         prescaler counter width; must satisfy 2**CNT_W >= TICK_DIV
// PORTS
//   CLK        in   1      system clock; all logic on rising edge
//   reset      in   1      asynchronous, active-high reset
//   sw         in   1      run enable: 1 = RUN, 0 = PAUSE
//   start      in   1      1-cycle pulse: load seed and (re)start
//   mode       in   2      00 rotate, 01 fill-zero, 10 bounce, 11 hold
//   dir        in   1      requested direction, 1 = left (toward MSB)
//   seed       in   WIDTH  pattern loaded on start
//   sr_q       in   WIDTH  current shift-register contents (feedback)
//   sr_load    out  1      parallel-load strobe to shift register
//   sr_data    out  WIDTH  parallel-load data; valid while sr_load = 1
//   sr_shift   out  1      shift strobe, one cycle per tick
//   sr_dir     out  1      shift direction; valid while sr_shift = 1
//   sr_ser_in  out  1      bit shifted in; valid while sr_shift = 1
//   tick       out  1      1-cycle pulse at every prescaler terminal count
//   busy       out  1      1 when state != IDLE
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset (async): state = IDLE, cnt = 0, dir_q = 0; every output = 0.
//   - Reset mid-operation clears the block immediately; no strobe follows until the next start.
//   - FSM states: IDLE, LOAD, RUN, PAUSE.
//   - IDLE: no strobes.
//       start -> LOAD.
//   - LOAD: lasts exactly 1 cycle.
//       sr_load = 1, sr_data = seed, cnt <= 0, dir_q <= dir.
//       Next state is RUN if sw = 1, otherwise PAUSE.
//   - RUN: cnt increments each cycle.
//       At cnt = TICK_DIV-1, cnt wraps to 0 and tick/action is issued the next cycle.
//       The first sr_shift comes exactly TICK_DIV cycles after the sr_load cycle.
//       Later sr_shift pulses are spaced TICK_DIV cycles apart.
//   - PAUSE is entered when sw = 0 in RUN.
//       cnt is frozen and no strobes are issued.
//       sw = 1 -> RUN; counting resumes from the frozen value.
//       A pause of P cycles delays the next tick by exactly P cycles.
//   - start in RUN or PAUSE -> LOAD.
//       start beats a same-cycle terminal count: no tick and no sr_shift in that cycle.
//   - Tick action uses mode sampled at the tick; a mode change takes effect at the next tick.
//     00 rotate:
//       dir_q <= dir; sr_shift = 1.
//       sr_ser_in = sr_q[WIDTH-1] when shifting left, sr_q[0] when shifting right.
//     01 fill-zero:
//       dir_q <= dir.
//       If sr_q != 0: sr_shift = 1, sr_ser_in = 0.
//       If sr_q == 0: sr_load = 1 with sr_data = seed, and no sr_shift.
//     10 bounce:
//       If dir_q = 1 and sr_q[WIDTH-1] = 1, dir_q flips to 0 and this tick shifts right.
//       If dir_q = 0 and sr_q[0] = 1, dir_q flips to 1 and this tick shifts left.
//       The dir input is ignored except at LOAD.
//       sr_ser_in uses the rotate rule.
//     11 hold: tick = 1; sr_shift = 0; sr_load = 0.
//   - sr_dir always equals the effective direction of the current shift.
//   - sr_load and sr_shift are never asserted in the same cycle.
//   - busy = 1 in LOAD, RUN and PAUSE.
// TESTING (TICK_DIV = 4; bench models an 8-bit shift register driven by sr_*)
//   1. mode 00, dir 1, seed 8'h01, start, sw = 1
//      -> one sr_load of 01, then sr_shift every 4 cycles.
//      -> sr_q sequence 02,04,...,80,01 (wraps).
//   2. sw = 0 for 6 cycles, 2 cycles after a tick
//      -> no strobes during the pause; next sr_shift arrives 4 + 6 = 10 cycles after the previous one.
//   3. mode 01, dir 1, seed 8'h03
//      -> after shifts 06,0C,...,80,00, the next tick gives sr_load with 03 and sr_shift = 0.
//   4. mode 10, dir 1, seed 8'h01
//      -> 01..80, then sr_dir = 0 (40,20,...,01), then sr_dir = 1 again; never passes MSB or LSB.
//   5. start in the same cycle as the terminal count; also mode 11
//      -> start case: sr_load only, no sr_shift, next tick 4 cycles later.
//      -> mode 11: tick pulses only.
//   6. reset = 1 mid-RUN, asynchronous to CLK
//      -> all outputs 0 before the next edge, busy = 0, no strobes until a new start.

Source files
------------

// File: rtl/led_shift_sequencer_if.sv
// led_shift_sequencer_if: control inputs and shift-register strobes between the sequencer and the LED datapath
interface led_shift_sequencer_if #(
   parameter int WIDTH = 8
);
   logic             sw;
   logic             start;
   logic [1:0]       mode;
   logic             dir;
   logic [WIDTH-1:0] seed;
   logic [WIDTH-1:0] sr_q;
   logic             sr_load;
   logic [WIDTH-1:0] sr_data;
   logic             sr_shift;
   logic             sr_dir;
   logic             sr_ser_in;
   logic             tick;
   logic             busy;
   modport master (
      input  sw, start, mode, dir, seed, sr_q,
      output sr_load, sr_data, sr_shift, sr_dir, sr_ser_in, tick, busy
   );
   modport slave (
      output sw, start, mode, dir, seed, sr_q,
      input  sr_load, sr_data, sr_shift, sr_dir, sr_ser_in, tick, busy
   );
endinterface

// File: rtl/led_shift_sequencer.sv
// led_shift_sequencer: prescaled tick generator issuing load/shift strobes to an LED shift register
module led_shift_sequencer #(
   parameter int WIDTH    = 8,
   parameter int TICK_DIV = 12500000,
   parameter int CNT_W    = 24
) (
   input logic                   CLK,
   input logic                   reset,
   led_shift_sequencer_if.master bus
);
   typedef enum logic [1:0] {IDLE, LOAD, RUN, PAUSE} state_t;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);
   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             dir_q, live, term, eff, refill, ser;
   always_comb begin
      live   = (state == RUN || state == PAUSE) && bus.sw;
      term   = live && cnt == LAST;
      eff    = bus.mode == 2'b10 ? dir_q ^ (dir_q ? bus.sr_q[WIDTH-1] : bus.sr_q[0]) : bus.dir;
      refill = bus.mode == 2'b01 && bus.sr_q == '0;
      ser    = bus.mode == 2'b01 ? 1'b0 : eff ? bus.sr_q[WIDTH-1] : bus.sr_q[0];
   end
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         dir_q         <= 1'b0;
         bus.sr_load   <= 1'b0;
         bus.sr_data   <= '0;
         bus.sr_shift  <= 1'b0;
         bus.sr_dir    <= 1'b0;
         bus.sr_ser_in <= 1'b0;
         bus.tick      <= 1'b0;
         bus.busy      <= 1'b0;
      end else begin
         bus.sr_load   <= 1'b0;
         bus.sr_data   <= '0;
         bus.sr_shift  <= 1'b0;
         bus.sr_dir    <= 1'b0;
         bus.sr_ser_in <= 1'b0;
         bus.tick      <= 1'b0;
         bus.busy      <= bus.start || state != IDLE;
         if (bus.start) begin
            state       <= LOAD;
            cnt         <= '0;
            bus.sr_load <= 1'b1;
            bus.sr_data <= bus.seed;
         end else if (state == LOAD) begin
            // the load cycle is the first prescaler cycle, so the first shift lands TICK_DIV after it
            state <= bus.sw ? RUN : PAUSE;
            cnt   <= CNT_W'(1);
            dir_q <= bus.dir;
         end else if (state != IDLE) begin
            state <= bus.sw ? RUN : PAUSE;
            if (live) cnt <= term ? '0 : cnt + CNT_W'(1);
            if (term) begin
               bus.tick <= 1'b1;
               if (bus.mode != 2'b11) begin
                  dir_q         <= eff;
                  bus.sr_load   <= refill;
                  bus.sr_data   <= refill ? bus.seed : '0;
                  bus.sr_shift  <= !refill;
                  bus.sr_dir    <= !refill && eff;
                  bus.sr_ser_in <= !refill && ser;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_led_shift_sequencer.sv
// tb_led_shift_sequencer: scenario and randomized checks of the sequencer driving a modelled 8-bit shift register
module tb_led_shift_sequencer;
   localparam int W  = 8;
   localparam int TD = 4;
   logic CLK = 1'b0;
   logic reset = 1'b1;
   led_shift_sequencer_if #(.WIDTH(W)) bus ();
   led_shift_sequencer #(.WIDTH(W), .TICK_DIV(TD), .CNT_W(3)) dut (.CLK(CLK), .reset(reset), .bus(bus));
   always #5 CLK = ~CLK;
   logic [7:0] sr = 8'h00;
   assign bus.sr_q = sr;
   always @(posedge CLK)
      if (bus.sr_load) sr <= bus.sr_data;
      else if (bus.sr_shift) sr <= bus.sr_dir ? {sr[6:0], bus.sr_ser_in} : {bus.sr_ser_in, sr[7:1]};
   int errors = 0;
   int checks = 0;
   int cyc = 0;
   // reference model: cycles remaining until the next tick, plus the expected pattern
   logic m_busy, m_loadcyc, m_dirq;
   int m_left;
   logic [7:0] m_pat = 8'h00;
   logic e_tick, e_busy, e_load, e_shift, e_dir, e_ser;
   logic [7:0] e_data;
   logic [13:0] obs, expv;
   assign obs  = {bus.tick, bus.busy, bus.sr_load, bus.sr_shift, bus.sr_dir, bus.sr_ser_in, bus.sr_data};
   assign expv = {e_tick, e_busy, e_load, e_shift, e_dir, e_ser, e_data};

   task automatic model_clear;
      m_busy = 0; m_loadcyc = 0; m_dirq = 0; m_left = TD;
      {e_tick, e_busy, e_load, e_shift, e_dir, e_ser} = '0;
      e_data = '0;
   endtask

   task automatic step;
      logic d;
      if (e_load) m_pat = e_data;
      else if (e_shift) m_pat = e_dir ? {m_pat[6:0], e_ser} : {e_ser, m_pat[7:1]};
      {e_tick, e_load, e_shift, e_dir, e_ser} = '0;
      e_data = '0;
      if (reset) model_clear();
      else if (bus.start) begin
         m_busy = 1; m_loadcyc = 1; e_load = 1; e_data = bus.seed;
      end else if (m_loadcyc) begin
         m_loadcyc = 0; m_dirq = bus.dir; m_left = TD - 1;
      end else if (m_busy && bus.sw) begin
         m_left--;
         if (m_left == 0) begin
            m_left = TD;
            e_tick = 1;
            case (bus.mode)
               2'd0: begin
                  d = bus.dir; m_dirq = d;
                  e_shift = 1; e_dir = d; e_ser = d ? m_pat[7] : m_pat[0];
               end
               2'd1: begin
                  m_dirq = bus.dir;
                  if (m_pat == 8'h00) begin e_load = 1; e_data = bus.seed; end
                  else begin e_shift = 1; e_dir = bus.dir; e_ser = 0; end
               end
               2'd2: begin
                  d = m_dirq;
                  if (d && m_pat[7]) d = 0;
                  else if (!d && m_pat[0]) d = 1;
                  m_dirq = d;
                  e_shift = 1; e_dir = d; e_ser = d ? m_pat[7] : m_pat[0];
               end
               default: ;
            endcase
         end
      end
      e_busy = m_busy;
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic test_reset;
      repeat (2) begin
         step();
         checks++;
         if (obs !== 14'h0) begin errors++; $display("FAIL reset cyc=%0d got=%h want=%h", cyc, obs, 14'h0); end
      end
      reset = 1'b0;
      repeat (3) begin
         step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL idle cyc=%0d got=%h want=%h", cyc, obs, expv); end
      end
   endtask

   task automatic test_rotate;
      logic [7:0] one = 8'h01;
      int k = 0;
      logic prev = 1'b0;
      bus.mode = 2'd0; bus.dir = 1'b1; bus.seed = 8'h01; bus.sw = 1'b1; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL rotate_load cyc=%0d got=%h want=%h", cyc, obs, expv); end
      repeat (38) begin
         step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL rotate cyc=%0d got=%h want=%h", cyc, obs, expv); end
         if (prev) begin
            k++;
            checks++;
            if (sr !== (one << (k % 8))) begin errors++; $display("FAIL rotate_seq shift=%0d got=%h want=%h", k, sr, one << (k % 8)); end
         end
         prev = bus.sr_shift;
      end
      checks++;
      if (k != 9) begin errors++; $display("FAIL rotate_count got=%0d want=9", k); end
   endtask

   task automatic test_pause;
      int t0;
      int strobes = 0;
      bit found = 0;
      for (int i = 0; i < 8 && !found; i++) begin
         step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL pause_pre cyc=%0d got=%h want=%h", cyc, obs, expv); end
         found = bus.sr_shift;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL pause_find got=no_shift want=shift within 8 cycles"); end
      t0 = cyc;
      repeat (2) begin
         step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL pause_run cyc=%0d got=%h want=%h", cyc, obs, expv); end
      end
      bus.sw = 1'b0;
      repeat (6) begin
         step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL pause cyc=%0d got=%h want=%h", cyc, obs, expv); end
         if (bus.sr_shift || bus.sr_load || bus.tick) strobes++;
      end
      bus.sw = 1'b1;
      found = 0;
      for (int i = 0; i < 12 && !found; i++) begin
         step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL pause_post cyc=%0d got=%h want=%h", cyc, obs, expv); end
         found = bus.sr_shift;
      end
      checks++;
      if (!found || cyc - t0 != 10) begin errors++; $display("FAIL pause_gap got=%0d want=10", cyc - t0); end
      checks++;
      if (strobes != 0) begin errors++; $display("FAIL pause_strobes got=%0d want=0", strobes); end
   endtask

   task automatic test_fill;
      int loads = 0;
      int shifts = 0;
      bus.mode = 2'd1; bus.dir = 1'b1; bus.seed = 8'h03; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      checks++;
      if (obs !== expv) begin errors++; $display("FAIL fill_load cyc=%0d got=%h want=%h", cyc, obs, expv); end
      repeat (38) begin
         step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL fill cyc=%0d got=%h want=%h", cyc, obs, expv); end
         if (bus.sr_load) loads++;
         if (bus.sr_shift) shifts++;
      end
      checks++;
      if (loads != 1 || shifts != 8) begin errors++; $display("FAIL fill_counts got=%0d/%0d want=1/8", loads, shifts); end
      checks++;
      if (sr !== 8'h03) begin errors++; $display("FAIL fill_reload got=%h want=03", sr); end
   endtask

   task automatic test_bounce;
      int k = 0;
      bus.mode = 2'd2; bus.dir = 1'b1; bus.seed = 8'h01; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (62) begin
         step();
         bus.dir = 1'($urandom);
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL bounce cyc=%0d got=%h want=%h", cyc, obs, expv); end
         checks++;
         if ($countones(sr) != 1) begin errors++; $display("FAIL bounce_onehot got=%h want=one bit set", sr); end
         if (bus.sr_shift) begin
            k++;
            checks++;
            if (bus.sr_dir !== (k <= 7 || k == 15)) begin
               errors++; $display("FAIL bounce_dir shift=%0d got=%b want=%b", k, bus.sr_dir, k <= 7 || k == 15);
            end
         end
      end
      checks++;
      if (k != 15) begin errors++; $display("FAIL bounce_count got=%0d want=15", k); end
   endtask

   task automatic test_start_terminal;
      int t1;
      bit found = 0;
      bus.mode = 2'd0; bus.dir = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL term_pre cyc=%0d got=%h want=%h", cyc, obs, expv); end
         found = bus.sr_shift;
      end
      checks++;
      if (!found) begin errors++; $display("FAIL term_find got=no_shift want=shift within 8 cycles"); end
      repeat (3) begin
         step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL term_wait cyc=%0d got=%h want=%h", cyc, obs, expv); end
      end
      bus.start = 1'b1; bus.seed = 8'hA5;
      step();
      bus.start = 1'b0;
      t1 = cyc;
      checks++;
      if ({bus.sr_load, bus.sr_shift, bus.tick, bus.sr_data} !== {3'b100, 8'hA5}) begin
         errors++; $display("FAIL term_start got=%b%b%b/%h want=100/a5", bus.sr_load, bus.sr_shift, bus.tick, bus.sr_data);
      end
      found = 0;
      for (int i = 0; i < 8 && !found; i++) begin
         step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL term_post cyc=%0d got=%h want=%h", cyc, obs, expv); end
         found = bus.sr_shift;
      end
      checks++;
      if (!found || cyc - t1 != 4) begin errors++; $display("FAIL term_gap got=%0d want=4", cyc - t1); end
   endtask

   task automatic test_hold;
      int ticks = 0;
      int strobes = 0;
      logic [7:0] snap;
      bus.mode = 2'd3;
      step();
      snap = sr;
      repeat (11) begin
         step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL hold cyc=%0d got=%h want=%h", cyc, obs, expv); end
         if (bus.tick) ticks++;
         if (bus.sr_shift || bus.sr_load) strobes++;
      end
      checks++;
      if (ticks != 3 || strobes != 0) begin errors++; $display("FAIL hold_counts got=%0d/%0d want=3/0", ticks, strobes); end
      checks++;
      if (sr !== snap) begin errors++; $display("FAIL hold_pattern got=%h want=%h", sr, snap); end
   endtask

   task automatic test_async_reset;
      int strobes = 0;
      bus.mode = 2'd0; bus.dir = 1'b1; bus.seed = 8'h81; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (6) begin
         step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL areset_pre cyc=%0d got=%h want=%h", cyc, obs, expv); end
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (obs !== 14'h0) begin errors++; $display("FAIL areset_now got=%h want=%h", obs, 14'h0); end
      model_clear();
      step();
      #2 reset = 1'b0;
      repeat (12) begin
         step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL areset_post cyc=%0d got=%h want=%h", cyc, obs, expv); end
         if (bus.sr_shift || bus.sr_load || bus.tick || bus.busy) strobes++;
      end
      checks++;
      if (strobes != 0) begin errors++; $display("FAIL areset_quiet got=%0d want=0", strobes); end
   endtask

   task automatic test_random;
      bus.seed = 8'($urandom); bus.start = 1'b1;
      for (int i = 0; i < 600; i++) begin
         step();
         checks++;
         if (obs !== expv) begin errors++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs, expv); end
         bus.sw = $urandom_range(0, 7) != 0;
         if ($urandom_range(0, 31) == 0) bus.mode = 2'($urandom_range(0, 3));
         bus.dir = 1'($urandom);
         bus.start = $urandom_range(0, 49) == 0;
         if (bus.start) bus.seed = 8'($urandom);
      end
      bus.start = 1'b0;
   endtask

   initial begin
      bus.sw = 1'b0; bus.start = 1'b0; bus.mode = 2'd0; bus.dir = 1'b0; bus.seed = 8'h00;
      model_clear();
      test_reset();
      test_rotate();
      test_pause();
      test_fill();
      test_bounce();
      test_start_terminal();
      test_hold();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
